// File: rtl/i2c_target_16b.sv
// Oversampled I2C target: ACKs its 7-bit address and moves one 16-bit word per transfer (MSB first).
// Optional build macro I2C_TARGET_GENCALL_EN also ACKs general-call writes to address 7'h00.

module i2c_target_16b_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  // Reset to 1 so an idle bus does not look like an edge when reset is released.
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) ff <= '1;
    else        ff <= {ff[STAGES-2:0], d};

  assign q = ff[STAGES-1];
endmodule

module i2c_target_16b #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SCL,
  input  logic        SDA_OUT,
  input  logic        SDA_OE,
  input  logic [6:0]  I2CS_ADDR,
  input  logic [15:0] RDS_DATA,
  output logic        SDA_IN,
  output logic [15:0] WRS_DATA,
  output logic        WR_STB,
  output logic        RD_STB,
  output logic        BUSY
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WR_BYTE  = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD_BYTE  = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;
  localparam logic [2:0] IGNORE   = 3'd7;

  logic [2:0]  state;
  logic [3:0]  bit_cnt;
  logic        byte_idx;
  logic [7:0]  rx_sr;
  logic [7:0]  wr_hi;
  logic [15:0] tx_sr;
  logic        sda_drv;

  logic        sda_line;
  logic [1:0]  raw, syn;
  logic        scl_s, sda_s, scl_d, sda_d;
  logic        scl_rise, scl_fall, start_c, stop_c, addr_hit;

  // Wired-AND of the master drive (pull-up when released) and our own drive.
  assign sda_line = (SDA_OE ? SDA_OUT : 1'b1) & SDA_IN;
  assign raw      = {SCL, sda_line};

  i2c_target_16b_sync #(.STAGES(SYNC_STAGES)) u_sync [1:0] (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (raw),
    .q     (syn)
  );

  assign scl_s    = syn[1];
  assign sda_s    = syn[0];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;

`ifdef I2C_TARGET_GENCALL_EN
  assign addr_hit = (rx_sr[7:1] == I2CS_ADDR) || ((rx_sr[7:1] == 7'h00) && !rx_sr[0]);
`else
  assign addr_hit = (rx_sr[7:1] == I2CS_ADDR);
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      byte_idx <= 1'b0;
      rx_sr    <= 8'h00;
      wr_hi    <= 8'h00;
      tx_sr    <= 16'h0000;
      sda_drv  <= 1'b1;
      SDA_IN   <= 1'b1;
      WRS_DATA <= 16'h0000;
      WR_STB   <= 1'b0;
      RD_STB   <= 1'b0;
      BUSY     <= 1'b0;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_d  <= scl_s;
      sda_d  <= sda_s;
      SDA_IN <= sda_drv;
      WR_STB <= 1'b0;
      RD_STB <= 1'b0;
      // Bus conditions override any SCL activity and abort a byte in flight.
      if (start_c) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_drv <= 1'b1;
      end else if (stop_c) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
        sda_drv <= 1'b1;
        BUSY    <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              rx_sr   <= {rx_sr[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (addr_hit) begin
                state    <= ADDR_ACK;
                sda_drv  <= 1'b0;
                BUSY     <= 1'b1;
                byte_idx <= 1'b0;
                tx_sr    <= RDS_DATA;
              end else begin
                state <= IGNORE;
                BUSY  <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (rx_sr[0]) begin
                state   <= RD_BYTE;
                sda_drv <= tx_sr[15];
                tx_sr   <= {tx_sr[14:0], 1'b0};
              end else begin
                state   <= WR_BYTE;
                sda_drv <= 1'b1;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              rx_sr   <= {rx_sr[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state   <= WR_ACK;
              sda_drv <= 1'b0;
              bit_cnt <= 4'd0;
              if (!byte_idx) wr_hi <= rx_sr;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_drv <= 1'b1;
              if (!byte_idx) begin
                byte_idx <= 1'b1;
                state    <= WR_BYTE;
              end else begin
                WRS_DATA <= {wr_hi, rx_sr};
                WR_STB   <= 1'b1;
                state    <= IGNORE;
              end
            end
          end
          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state   <= RD_ACK;
                sda_drv <= 1'b1;
                bit_cnt <= 4'd0;
              end else begin
                sda_drv <= tx_sr[15];
                tx_sr   <= {tx_sr[14:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            // Byte 1 completes the word whether the master ACKs or NACKs it.
            if (scl_rise) begin
              if (byte_idx) begin
                RD_STB <= 1'b1;
                state  <= IGNORE;
              end else if (!sda_s) begin
                byte_idx <= 1'b1;
                state    <= RD_BYTE;
              end else begin
                state <= IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target_16b.sv
// Directed bench for i2c_target_16b: bit-level I2C master tasks plus strobe monitors.
module tb_i2c_target_16b;
  localparam int H = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        SCL = 1'b1;
  logic        SDA_OUT = 1'b1;
  logic        SDA_OE = 1'b0;
  logic [6:0]  I2CS_ADDR = 7'b0011010;
  logic [15:0] RDS_DATA = 16'h0000;
  logic        SDA_IN;
  logic [15:0] WRS_DATA;
  logic        WR_STB, RD_STB, BUSY;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, long_cnt = 0, low_cnt = 0;
  logic wr_prev = 1'b0, rd_prev = 1'b0;

  wire sda_bus = (SDA_OE ? SDA_OUT : 1'b1) & SDA_IN;

  i2c_target_16b #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .SCL(SCL), .SDA_OUT(SDA_OUT), .SDA_OE(SDA_OE),
    .I2CS_ADDR(I2CS_ADDR), .RDS_DATA(RDS_DATA), .SDA_IN(SDA_IN),
    .WRS_DATA(WRS_DATA), .WR_STB(WR_STB), .RD_STB(RD_STB), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (WR_STB) wr_cnt++;
    if (RD_STB) rd_cnt++;
    if (WR_STB && RD_STB) both_cnt++;
    if ((WR_STB && wr_prev) || (RD_STB && rd_prev)) long_cnt++;
    if (!SDA_IN) low_cnt++;
    wr_prev = WR_STB;
    rd_prev = RD_STB;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clock_bit(input logic oe, input logic v, output logic rd);
    SDA_OE = oe; SDA_OUT = v;
    wclk(H);
    SCL = 1'b1;
    wclk(H/2);
    rd = sda_bus;
    wclk(H/2);
    SCL = 1'b0;
    wclk(2);
  endtask

  task automatic i2c_start();
    SDA_OE = 1'b1; SDA_OUT = 1'b1;
    wclk(H);
    SCL = 1'b1;
    wclk(H);
    SDA_OUT = 1'b0;
    wclk(H);
    SCL = 1'b0;
    wclk(2);
  endtask

  task automatic i2c_stop();
    SDA_OE = 1'b1; SDA_OUT = 1'b0;
    wclk(H);
    SCL = 1'b1;
    wclk(H);
    SDA_OUT = 1'b1;
    wclk(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, b[i], r);
    clock_bit(1'b0, 1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b0, 1'b1, r);
      d[i] = r;
    end
    clock_bit(mack, 1'b0, r);
  endtask

  task automatic write_word(input logic [6:0] a, input logic [15:0] w,
                            output logic a0, output logic a1, output logic a2);
    i2c_start();
    write_byte({a, 1'b0}, a0);
    write_byte(w[15:8], a1);
    write_byte(w[7:0], a2);
  endtask

  initial begin
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    int wr0, rd0, low0;
    logic exp_gc_ack;
    logic [15:0] exp_gc_wrs;
    int exp_gc_inc;

    // Reset held with a noisy bus
    for (int i = 0; i < 6; i++) begin
      SCL = 1'($urandom_range(0, 1));
      SDA_OUT = 1'($urandom_range(0, 1));
      SDA_OE = 1'($urandom_range(0, 1));
      wclk(3);
      chk("rst_sda_in", 32'(SDA_IN), 32'd1);
      chk("rst_wrs", 32'(WRS_DATA), 32'h0);
      chk("rst_wr_stb", 32'(WR_STB), 32'd0);
      chk("rst_rd_stb", 32'(RD_STB), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
    end
    SCL = 1'b1; SDA_OE = 1'b1; SDA_OUT = 1'b1;
    wclk(2);
    RESET = 1'b1;
    wclk(10);
    chk("idle_sda_in", 32'(SDA_IN), 32'd1);

    // Write 16'hAAAD to own address
    write_word(7'b0011010, 16'hAAAD, a0, a1, a2);
    chk("wr1_ack_addr", 32'(a0), 32'd1);
    chk("wr1_ack_b0", 32'(a1), 32'd1);
    chk("wr1_ack_b1", 32'(a2), 32'd1);
    chk("wr1_busy", 32'(BUSY), 32'd1);
    i2c_stop();
    chk("wr1_data", 32'(WRS_DATA), 32'hAAAD);
    chk("wr1_stb_cnt", 32'(wr_cnt), 32'd1);
    chk("wr1_busy_after_stop", 32'(BUSY), 32'd0);

    // Read 16'hEEED; RDS_DATA changes after the address must not matter
    RDS_DATA = 16'hEEED;
    i2c_start();
    write_byte({7'b0011010, 1'b1}, a0);
    RDS_DATA = 16'h0000;
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    chk("rd_ack_addr", 32'(a0), 32'd1);
    chk("rd_bits", 32'({d0, d1}), 32'hEEED);
    chk("rd_stb_cnt", 32'(rd_cnt), 32'd1);
    chk("rd_busy", 32'(BUSY), 32'd1);
    i2c_stop();
    chk("rd_busy_after_stop", 32'(BUSY), 32'd0);
    chk("rd_no_wr_stb", 32'(wr_cnt), 32'd1);

    // Read NACKed on byte 0: no RD_STB
    RDS_DATA = 16'h5A3C;
    i2c_start();
    write_byte({7'b0011010, 1'b1}, a0);
    read_byte(1'b0, d0);
    i2c_stop();
    chk("rdnack_byte0", 32'(d0), 32'h5A);
    chk("rdnack_no_stb", 32'(rd_cnt), 32'd1);

    // Wrong address: never pulls SDA low
    low0 = low_cnt;
    write_word(7'b0011011, 16'h1111, a0, a1, a2);
    i2c_stop();
    chk("bad_ack", 32'({a0, a1, a2}), 32'd0);
    chk("bad_sda_low", 32'(low_cnt - low0), 32'd0);
    chk("bad_wrs", 32'(WRS_DATA), 32'hAAAD);
    chk("bad_wr_stb", 32'(wr_cnt), 32'd1);
    chk("bad_rd_stb", 32'(rd_cnt), 32'd1);

    // Back-to-back writes, then aborted third write
    wr0 = wr_cnt;
    write_word(7'b0011010, 16'hAAAD, a0, a1, a2);
    i2c_stop();
    chk("b2b_1", 32'(WRS_DATA), 32'hAAAD);
    write_word(7'b0011010, 16'hEABD, a0, a1, a2);
    i2c_stop();
    chk("b2b_2", 32'(WRS_DATA), 32'hEABD);
    i2c_start();
    write_byte({7'b0011010, 1'b0}, a0);
    write_byte(8'h11, a1);
    chk("abort_acks", 32'({a0, a1}), 32'd3);
    i2c_start();
    i2c_stop();
    chk("abort_wrs", 32'(WRS_DATA), 32'hEABD);
    chk("abort_stb_cnt", 32'(wr_cnt - wr0), 32'd2);

    // General call write
`ifdef I2C_TARGET_GENCALL_EN
    exp_gc_ack = 1'b1; exp_gc_wrs = 16'h1234; exp_gc_inc = 1;
`else
    exp_gc_ack = 1'b0; exp_gc_wrs = 16'hEABD; exp_gc_inc = 0;
`endif
    wr0 = wr_cnt;
    write_word(7'h00, 16'h1234, a0, a1, a2);
    i2c_stop();
    chk("gc_ack", 32'(a0), 32'(exp_gc_ack));
    chk("gc_wrs", 32'(WRS_DATA), 32'(exp_gc_wrs));
    chk("gc_stb", 32'(wr_cnt - wr0), 32'(exp_gc_inc));

    // Asynchronous reset while the target drives the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      logic bval;
      logic [7:0] ab;
      ab = {7'b0011010, 1'b0};
      clock_bit(1'b1, ab[i], bval);
    end
    SDA_OE = 1'b0;
    wclk(H);
    chk("mid_ack_low", 32'(SDA_IN), 32'd0);
    chk("mid_busy", 32'(BUSY), 32'd1);
    RESET = 1'b0;
    #2;
    chk("async_sda_in", 32'(SDA_IN), 32'd1);
    chk("async_busy", 32'(BUSY), 32'd0);
    chk("async_wrs", 32'(WRS_DATA), 32'h0);
    SCL = 1'b1; SDA_OE = 1'b1; SDA_OUT = 1'b1;
    wclk(3);
    RESET = 1'b1;
    wclk(5);

    chk("stb_overlap", 32'(both_cnt), 32'd0);
    chk("stb_width", 32'(long_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_target_16b.md
# i2c_target_16b

I2C target (responder) for the two-byte master used in the Tarea05 I2C benches. It watches SCL and the master's SDA drive, and acknowledges its 7-bit address. On a write it accepts a 16-bit word; on a read it returns a 16-bit word, MSB first. The block is oversampled: every signal runs on the system clock CLK, so SCL is treated as data and is not a clock.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth on SCL and the sampled SDA line (minimum 2).

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  reset, asynchronous and active-low.
- SCL  input  1  bus clock from the master.
- SDA_OUT  input  1  master's SDA value.
- SDA_OE  input  1  master drive enable. The effective master line is SDA_OUT when SDA_OE=1, else 1 (pull-up).
- I2CS_ADDR  input  7  own target address.
- RDS_DATA  input  16  word returned on reads.
- SDA_IN  output  1  target's SDA toward the master. 0 pulls the line low; 1 releases it.
- WRS_DATA  output  16  last complete word written by the master.
- WR_STB  output  1  one-CLK pulse when WRS_DATA updates.
- RD_STB  output  1  one-CLK pulse when a full 16-bit read completes.
- BUSY  output  1  high from START to STOP while addressed.

## Operation
- Line sampled: sda = (SDA_OE ? SDA_OUT : 1) & SDA_IN. Both SCL and sda pass through SYNC_STAGES flops, then an edge detect.
- START: sda falls while SCL=1. It is accepted in any state, including a repeated START. The FSM goes to ADDR, the bit counter clears, and SDA_IN=1.
- STOP: sda rises while SCL=1. It is accepted in any state. The FSM goes to IDLE, SDA_IN=1 and BUSY=0.
- Data is sampled on SCL rising edges. SDA_IN changes only on SCL falling edges.
- FSM states and transitions:
  - IDLE → ADDR on START.
  - ADDR: shifts in 8 bits (address[6:0], then RNW).
    - Address matches I2CS_ADDR → ADDR_ACK. BUSY=1, byte index 0, and RDS_DATA is latched into the TX shift register.
    - No match → IGNORE.
  - ADDR_ACK: SDA_IN=0 for the 9th SCL high. On the following SCL fall: RNW=0 → WR_BYTE; RNW=1 → RD_BYTE, and SDA_IN takes the TX MSB.
  - WR_BYTE: shifts 8 bits into the RX register → WR_ACK.
  - WR_ACK:
    - Byte 0 → ACK and return to WR_BYTE.
    - Byte 1 → ACK. At the SCL fall that ends the ACK, WRS_DATA ← RX and WR_STB=1; then go to IGNORE.
    - A third write byte never occurs, because IGNORE keeps SDA released, so extra bytes are NACKed.
  - RD_BYTE: drives 8 TX bits, one per SCL low phase → RD_ACK with SDA_IN released.
  - RD_ACK: samples the master's ACK on the 9th SCL rise.
    - Byte 0 ACKed → RD_BYTE.
    - Byte 0 NACKed → IGNORE, no RD_STB.
    - Byte 1 (ACK or NACK) → RD_STB=1, then IGNORE.
  - IGNORE: SDA_IN=1. Leaves only on START or STOP.
- A START or STOP in the middle of a byte aborts the transfer. WRS_DATA is not updated and no strobe is produced.
- A START or STOP occurring on the same CLK as an SCL edge takes priority.

## Timing
- Reset values: SDA_IN=1, WRS_DATA=16'h0000, WR_STB=0, RD_STB=0, BUSY=0, FSM=IDLE, counters 0.
- Asserting RESET mid-transfer returns these values immediately, with no clock needed.
- Latency from a raw SCL or sda transition to the FSM reaction is SYNC_STAGES+1 CLK. SDA_IN registers one CLK later.
- The master must hold each SCL phase for at least SYNC_STAGES+3 CLK.
- WR_STB and RD_STB are exactly one CLK wide and never asserted together.
- RDS_DATA is sampled only at the address match. Later changes do not affect a read already in progress.

## Configuration
- I2C_TARGET_GENCALL_EN
  - Defined: address 7'h00 with RNW=0 is ACKed and handled as a normal two-byte write (WRS_DATA, WR_STB). Address 7'h00 with RNW=1 is NACKed.
  - Undefined: only I2CS_ADDR matches. I2CS_ADDR=7'h00 is illegal.

## Test plan
- Reset: hold RESET=0 with random SCL/SDA → all outputs hold their reset values. Release with SCL=sda=1 → IDLE.
- Write, address 7'b0011010, data 16'hAAAD → ACK on all three bytes, WRS_DATA=16'hAAAD, one WR_STB pulse, BUSY=0 after STOP.
- Read, RNW=1, RDS_DATA=16'hEEED; master ACKs byte 0 and NACKs byte 1 → SDA_IN bitstream 1110_1110_1110_1101, one RD_STB pulse.
- Wrong address 7'b0011011 write → SDA_IN=1 throughout, WRS_DATA unchanged, no strobes.
- Back-to-back writes 16'hAAAD then 16'hEABD separated by STOP. Then a repeated START after byte 0 of a third write → WRS_DATA=16'hEABD, exactly two WR_STB pulses.
- With I2C_TARGET_GENCALL_EN: write to address 7'h00, data 16'h1234 → ACKed, WRS_DATA=16'h1234. Without the macro, the same stimulus → NACK and no update.
